// File: rtl/cmp_pkg.sv
// Shared types for the serial magnitude comparator: FSM states, result
// encoding and the encoding-to-one-hot mapping.
package cmp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        EQ = 2'd0,
        GT = 2'd1,
        LT = 2'd2
    } res_e;

    // Returns {gt, eq, lt}; the unused code maps to "equal" to keep one-hot.
    function automatic logic [2:0] res_onehot(input res_e r);
        case (r)
            GT:      return 3'b100;
            LT:      return 3'b001;
            default: return 3'b010;
        endcase
    endfunction

endpackage

// File: rtl/serial_shift_word.sv
// Clear/enable serial-in shift register that reassembles one operand word,
// MSB-first (shift left) or LSB-first (shift right).
module serial_shift_word #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic             bit_i,
    output logic [WIDTH-1:0] word_o
);

    logic [WIDTH-1:0] word_q;
    logic [WIDTH-1:0] word_d;

    always_comb begin
        word_d = word_q;
        if (MSB_FIRST) begin
            word_d = {word_q[WIDTH-2:0], bit_i};
        end else begin
            word_d = {bit_i, word_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q <= '0;
        end else if (clr_i) begin
            word_q <= '0;
        end else if (en_i) begin
            word_q <= word_d;
        end
    end

    assign word_o = word_q;

endmodule

// File: rtl/serial_mag_cmp.sv
// Sequential multi-bit unsigned comparator: accumulates WIDTH bit pairs from
// the serial a/b streams and reports greater/equal/less plus both words.
module serial_mag_cmp
    import cmp_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       bit_valid,
    input  logic                       a_bit,
    input  logic                       b_bit,
    output logic                       busy,
    output logic                       done,
    output logic                       a_gt,
    output logic                       a_eq,
    output logic                       a_lt,
    output logic [WIDTH-1:0]           a_word,
    output logic [WIDTH-1:0]           b_word,
    output logic [$clog2(WIDTH+1)-1:0] bit_cnt
);

    localparam int CW = $clog2(WIDTH+1);

    state_e        state_q, state_d;
    res_e          dec_q, dec_d;
    res_e          res_q, res_d;
    logic          done_q, done_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          clr;
    logic          accept;

    always_comb begin
        state_d = state_q;
        dec_d   = dec_q;
        res_d   = res_q;
        done_d  = 1'b0;
        cnt_d   = cnt_q;
        clr     = 1'b0;
        accept  = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = SHIFT;
                    clr     = 1'b1;
                    cnt_d   = '0;
                    dec_d   = EQ;
                    res_d   = EQ;
                end
            end
            SHIFT: begin
                if (bit_valid) begin
                    accept = 1'b1;
                    cnt_d  = cnt_q + CW'(1);
                    // MSB-first: first difference is final; LSB-first: last difference wins.
                    if ((a_bit != b_bit) && (!MSB_FIRST || (dec_q == EQ))) begin
                        dec_d = a_bit ? GT : LT;
                    end
                    if (cnt_q == CW'(WIDTH-1)) begin
                        state_d = DONE;
                        res_d   = dec_d;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            dec_q   <= EQ;
            res_q   <= EQ;
            done_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            dec_q   <= dec_d;
            res_q   <= res_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
        end
    end

    serial_shift_word #(
        .WIDTH    (WIDTH),
        .MSB_FIRST(MSB_FIRST)
    ) u_word_a (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (clr),
        .en_i  (accept),
        .bit_i (a_bit),
        .word_o(a_word)
    );

    serial_shift_word #(
        .WIDTH    (WIDTH),
        .MSB_FIRST(MSB_FIRST)
    ) u_word_b (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (clr),
        .en_i  (accept),
        .bit_i (b_bit),
        .word_o(b_word)
    );

    assign busy               = (state_q == SHIFT);
    assign done               = done_q;
    assign {a_gt, a_eq, a_lt} = res_onehot(res_q);
    assign bit_cnt            = cnt_q;

endmodule
